prog_pattern_timer: RTL and testbench

PROG_PATTERN_TIMER -- requirements
Module: prog_pattern_timer

---
 rtl/prog_pattern_timer.sv | 159 +++++++++++++++
 tb/tb_prog_pattern_timer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/prog_pattern_timer.sv
`default_nettype none
// ============================================================================
// Module      : prog_pattern_timer
// Description : Serial pattern detector that captures a programmed delay and
//               times it out in units of TICK_CNT clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_pattern_timer #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PATTERN  = 4'b1101,
    parameter int               DELAY_W  = 4,
    parameter int               TICK_CNT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    input  logic               abort,
    output logic               shift_ena,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);

    localparam int c_fill_w = $clog2(PAT_W);
    localparam int c_load_w = $clog2(DELAY_W + 1);
    localparam int c_tick_w = ($clog2(TICK_CNT) > 1) ? $clog2(TICK_CNT) : 1;

    localparam logic [c_fill_w-1:0] c_fill_max  = c_fill_w'(PAT_W - 1);
    localparam logic [c_load_w-1:0] c_load_last = c_load_w'(DELAY_W - 1);
    localparam logic [c_tick_w-1:0] c_tick_max  = c_tick_w'(TICK_CNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOAD   = 2'd1,
        COUNT  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PAT_W-2:0]    r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic [DELAY_W-1:0]  r_delay;
    logic [c_load_w-1:0] r_load;
    logic [c_tick_w-1:0] r_tick;
    logic [DELAY_W-1:0]  r_count;

    logic [PAT_W-1:0]    w_shift;
    logic [DELAY_W-1:0]  w_delay_next;
    logic                w_match;

    assign w_shift      = {r_hist, data};
    assign w_delay_next = DELAY_W'({r_delay, data});
    assign w_match      = (r_fill == c_fill_max) && (w_shift == PATTERN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        shift_ena = 1'b0;
        counting  = 1'b0;
        done      = 1'b0;
        count     = '0;
        case (r_state)
            SEARCH: begin
                if (!abort && w_match) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                shift_ena = 1'b1;
                if (abort) begin
                    w_next = SEARCH;
                end else if (r_load == c_load_last) begin
                    w_next = COUNT;
                end
            end
            COUNT: begin
                counting = 1'b1;
                count    = r_count;
                if (abort) begin
                    w_next = SEARCH;
                end else if ((r_tick == '0) && (r_count == '0)) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                done = 1'b1;
                if (abort || ack) begin
                    w_next = SEARCH;
                end
            end
            default: begin
                w_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_delay <= '0;
            r_load  <= '0;
            r_tick  <= '0;
            r_count <= '0;
        end else begin
            // History only accumulates while searching, so every return to
            // SEARCH starts from an empty window.
            if (r_state != SEARCH) begin
                r_hist <= '0;
                r_fill <= '0;
            end
            case (r_state)
                SEARCH: begin
                    r_load <= '0;
                    if (abort) begin
                        r_hist <= '0;
                        r_fill <= '0;
                    end else begin
                        r_hist <= w_shift[PAT_W-2:0];
                        if (r_fill != c_fill_max) begin
                            r_fill <= r_fill + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_delay <= w_delay_next;
                    r_load  <= r_load + 1'b1;
                    if (r_load == c_load_last) begin
                        r_count <= w_delay_next;
                        r_tick  <= c_tick_max;
                    end
                end
                COUNT: begin
                    if (r_tick == '0) begin
                        if (r_count != '0) begin
                            r_count <= r_count - 1'b1;
                            r_tick  <= c_tick_max;
                        end
                    end else begin
                        r_tick <= r_tick - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_pattern_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_pattern_timer
// Description : Directed self-checking bench for prog_pattern_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_pattern_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       data;
    logic       ack;
    logic       abort;
    logic       shift_ena;
    logic       counting;
    logic       done;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    prog_pattern_timer #(
        .PAT_W    (4),
        .PATTERN  (4'b1101),
        .DELAY_W  (4),
        .TICK_CNT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .ack       (ack),
        .abort     (abort),
        .shift_ena (shift_ena),
        .counting  (counting),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic d, input logic a, input logic ab);
        data  = d;
        ack   = a;
        abort = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic sh, input logic cn,
                       input logic dn, input logic [3:0] cnt);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {shift_ena, counting, done, count};
        exp = {sh, cn, dn, cnt};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Feeds bits MSB first; only the final bit may complete a match.
    task automatic search_seq(input string tag, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b0, 1'b0);
            if (i > 0) chk(tag, 1'b0, 1'b0, 1'b0, 4'd0);
            else       chk(tag, 1'b1, 1'b0, 1'b0, 4'd0);
        end
    endtask

    task automatic load_delay(input string tag, input logic [3:0] d);
        for (int i = 3; i >= 0; i--) begin
            step(d[i], 1'b0, 1'b0);
            if (i > 0) chk(tag, 1'b1, 1'b0, 1'b0, 4'd0);
            else       chk(tag, 1'b0, 1'b1, 1'b0, d);
        end
    endtask

    initial begin
        reset = 1'b1;
        data  = 1'b0;
        ack   = 1'b0;
        abort = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;

        // Basic trigger, delay 2 -> 12 counting cycles
        search_seq("match_1101", 8'b0000_1101, 4);
        load_delay("load_0010", 4'b0010);
        for (int i = 0; i < 12; i++) begin
            chk("count_d2", 1'b0, 1'b1, 1'b0, (i < 4) ? 4'd2 : (i < 8) ? 4'd1 : 4'd0);
            step((i % 3) != 2, 1'b0, 1'b0);
        end
        chk("done_d2", 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("wait_hold", 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("ack_release", 1'b0, 1'b0, 1'b0, 4'd0);

        // Overlapping patterns
        search_seq("match_11101", 8'b0001_1101, 5);
        step(1'b0, 1'b0, 1'b1);
        chk("abort_load", 1'b0, 1'b0, 1'b0, 4'd0);
        search_seq("match_11001101", 8'b1100_1101, 8);

        // Zero delay -> exactly TICK_CNT counting cycles
        load_delay("load_0000", 4'b0000);
        for (int i = 0; i < 4; i++) begin
            chk("count_d0", 1'b0, 1'b1, 1'b0, 4'd0);
            step(1'b0, 1'b0, 1'b0);
        end
        chk("done_d0", 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("ack_d0", 1'b0, 1'b0, 1'b0, 4'd0);

        // Abort in COUNT cycle 3; bits seen while counting must not leak
        search_seq("match_abort", 8'b0000_1101, 4);
        load_delay("load_0001a", 4'b0001);
        step(1'b1, 1'b0, 1'b0);
        chk("count_c2", 1'b0, 1'b1, 1'b0, 4'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("count_c3", 1'b0, 1'b1, 1'b0, 4'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("abort_count", 1'b0, 1'b0, 1'b0, 4'd0);
        search_seq("fresh_1101", 8'b0000_1101, 4);

        // Reset during LOAD bit 2
        step(1'b1, 1'b0, 1'b0);
        chk("load_bit1", 1'b1, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("reset_load", 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;

        // ack during COUNT is ignored
        search_seq("match_ack", 8'b0000_1101, 4);
        load_delay("load_0001b", 4'b0001);
        for (int i = 0; i < 8; i++) begin
            chk("count_d1", 1'b0, 1'b1, 1'b0, (i < 4) ? 4'd1 : 4'd0);
            step(1'b0, (i == 1), 1'b0);
        end
        chk("done_d1", 1'b0, 1'b0, 1'b1, 4'd0);

        // done held for 20 cycles, then ack and retrigger
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("done_hold", 1'b0, 1'b0, 1'b1, 4'd0);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("ack_final", 1'b0, 1'b0, 1'b0, 4'd0);
        search_seq("retrigger", 8'b0000_1101, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
